// File: rtl/rib_arbiter_pkg.sv
// Shared constants and types for the RIB bus arbiter.
// Default master count, index width and class masks for the SoC's four RIB masters.
package rib_arbiter_pkg;

  localparam int RIB_NUM_M = 4;
  localparam int RIB_IDX_W = 2;
  localparam logic [RIB_NUM_M-1:0] RIB_HI_MASK   = 4'b1100;
  localparam logic [RIB_NUM_M-1:0] RIB_CORE_MASK = 4'b0011;

  // Which rule produced the next grant; decides which round-robin pointer moves.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_KEEP,
    SRC_HI,
    SRC_LO
  } grant_src_e;

endpackage

// File: rtl/rib_arbiter_if.sv
// Request/grant bundle between the RIB masters and the arbiter.
interface rib_arbiter_if
  import rib_arbiter_pkg::*;
#(
  parameter int NUM_M = RIB_NUM_M,
  parameter int IDX_W = RIB_IDX_W
);

  logic [NUM_M-1:0] req_i;
  logic [NUM_M-1:0] lock_i;
  logic [NUM_M-1:0] gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic             gnt_valid_o;
  logic             hold_o;

  modport master (output req_i, lock_i, input gnt_o, gnt_idx_o, gnt_valid_o, hold_o);
  modport slave  (input req_i, lock_i, output gnt_o, gnt_idx_o, gnt_valid_o, hold_o);

endinterface

// File: rtl/rib_arbiter_rr_pick.sv
// Round-robin picker: first request at or after ptr (wrapping), skipping excluded masters.
module rr_pick
  import rib_arbiter_pkg::*;
#(
  parameter int NUM_M = RIB_NUM_M,
  parameter int IDX_W = RIB_IDX_W
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [NUM_M-1:0] excl,
  output logic [NUM_M-1:0] win,
  output logic             found
);

  logic [NUM_M-1:0] cand;
  logic [IDX_W-1:0] idx;

  assign cand = req & ~excl;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_M);
      if (!found && cand[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Two-class round-robin RIB arbiter with bounded lock bursts and starvation override.
// Registered one-hot grant drives the RIB address/data mux; hold stalls the core.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int                   NUM_M        = RIB_NUM_M,
  parameter logic [NUM_M-1:0]     HI_MASK      = RIB_HI_MASK,
  parameter logic [NUM_M-1:0]     CORE_MASK    = RIB_CORE_MASK,
  parameter int                   MAX_LOCK     = 8,
  parameter int                   STARVE_LIMIT = 16
) (
  input  logic          sysclk,
  input  logic          rst,
  rib_arbiter_if.slave  bus
);

  localparam int IDX_W  = RIB_IDX_W;
  localparam int LCNT_W = $clog2(MAX_LOCK + 1);
  localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LCNT_W-1:0] LOCK_LAST  = LCNT_W'(MAX_LOCK - 1);
  localparam logic [WCNT_W-1:0] STARVE_MAX = WCNT_W'(STARVE_LIMIT);

  logic [NUM_M-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hold_q;
  logic [IDX_W-1:0]  last_hi, last_lo;
  logic [LCNT_W-1:0] lock_cnt, lock_cnt_d;
  logic [WCNT_W-1:0] wait_cnt [NUM_M];

  logic              owner_live, lock_ok, lock_out;
  logic [NUM_M-1:0]  excl, starve, starve_win;
  logic [NUM_M-1:0]  hi_win, lo_win;
  logic              hi_found, lo_found;
  logic [IDX_W-1:0]  hi_ptr, lo_ptr;
  grant_src_e        src;

  // The owner wants to continue a burst; whether it may depends on the lock budget.
  assign owner_live = |(gnt_q & bus.req_i & bus.lock_i);
  assign lock_ok    = owner_live && (lock_cnt < LOCK_LAST);
  assign lock_out   = owner_live && !lock_ok;
  assign excl       = lock_out ? gnt_q : '0;

  assign hi_ptr = IDX_W'((int'(last_hi) + 1) % NUM_M);
  assign lo_ptr = IDX_W'((int'(last_lo) + 1) % NUM_M);

  always_comb begin
    starve     = '0;
    starve_win = '0;
    for (int i = 0; i < NUM_M; i++) begin
      starve[i] = !HI_MASK[i] && bus.req_i[i] && (wait_cnt[i] == STARVE_MAX);
    end
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (starve[i]) starve_win = NUM_M'(1) << i;
    end
  end

  rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick_hi (
    .req   (bus.req_i & HI_MASK),
    .ptr   (hi_ptr),
    .excl  (excl),
    .win   (hi_win),
    .found (hi_found)
  );

  rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick_lo (
    .req   (bus.req_i & ~HI_MASK),
    .ptr   (lo_ptr),
    .excl  (excl),
    .win   (lo_win),
    .found (lo_found)
  );

  always_comb begin
    gnt_d      = '0;
    lock_cnt_d = '0;
    src        = SRC_NONE;
    if (lock_ok) begin
      gnt_d      = gnt_q;
      lock_cnt_d = lock_cnt + 1'b1;
      src        = SRC_KEEP;
    end else if (|starve) begin
      gnt_d = starve_win;
      src   = SRC_LO;
    end else if (hi_found) begin
      gnt_d = hi_win;
      src   = SRC_HI;
    end else if (lo_found) begin
      gnt_d = lo_win;
      src   = SRC_LO;
    end else if (lock_out) begin
      // Budget spent but nobody else is asking: start a fresh burst.
      gnt_d = gnt_q;
      src   = SRC_KEEP;
    end
  end

  always_comb begin
    idx_d = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_d[i]) idx_d = IDX_W'(i);
    end
  end

  always_ff @(posedge sysclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      gnt_q    <= '0;
      idx_q    <= '0;
      hold_q   <= 1'b0;
      last_hi  <= IDX_W'(NUM_M - 1);
      last_lo  <= IDX_W'(NUM_M - 1);
      lock_cnt <= '0;
      // NOTE: the wait counters are a few flops, not a RAM, so they reset with everything else.
      for (int i = 0; i < NUM_M; i++) wait_cnt[i] <= '0;
    end else begin
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      hold_q   <= |(gnt_d & ~CORE_MASK);
      lock_cnt <= lock_cnt_d;
      if (src == SRC_HI) last_hi <= idx_d;
      if (src == SRC_LO) last_lo <= idx_d;
      for (int i = 0; i < NUM_M; i++) begin
        if (HI_MASK[i] || !bus.req_i[i] || gnt_d[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != STARVE_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = |gnt_q;
  assign bus.hold_o      = hold_q;

endmodule
